serial_in_parallel_out_framed: RTL
==================================

Name: serial_in_parallel_out_framed

Overview:
- Framed serial-to-parallel deserializer that sits directly upstream of the 8-bit parallel register stage.
- Shifts in one serial bit per enabled clock and counts WIDTH bits per frame.
- Presents each completed word on a held parallel output with a valid/ready handshake, so the next stage captures whole words only.
- Flags overrun when a new word completes while the previous word is still unconsumed.

Parameters:
- WIDTH, 8, bits per word; legal values are 2..32.
- MSB_FIRST, 1, 1 = first received bit lands in bit WIDTH-1; 0 = first received bit lands in bit 0.
- CONTINUOUS, 0, 1 = stay in RECEIVE after a word completes; 0 = return to IDLE and wait for the next Frame_Start_In.

Ports:
- Clk_In  input  1  single clock; all state updates on the falling edge.
- Reset_In  input  1  asynchronous, active-high reset.
- Serial_Data_In  input  1  serial data bit, sampled when Shift_En_In=1.
- Shift_En_In  input  1  bit strobe; one bit is captured per edge where this input is high.
- Frame_Start_In  input  1  marks the current bit as bit 0 of a new frame; qualified by Shift_En_In.
- Data_Ready_In  input  1  downstream accepts the word on an edge where Data_Valid_Out=1.
- Overrun_Clear_In  input  1  synchronous clear of Overrun_Out.
- Parallel_Data_Out  output  WIDTH  completed word; held stable while Data_Valid_Out=1.
- Data_Valid_Out  output  1  word available.
- Overrun_Out  output  1  sticky flag: a completed word was dropped.
- Bit_Count_Out  output  $clog2(WIDTH+1)  bits captured in the current frame.

Behaviour:
- Clocking and reset:
  - Single clock domain, falling-edge registers.
  - Reset_In=1 asynchronously forces: state=IDLE, shift register=0, Bit_Count_Out=0, Parallel_Data_Out=0, Data_Valid_Out=0, Overrun_Out=0.
  - Reset asserted mid-frame discards the partial word and any held word.
- States:
  - IDLE: captured bits are ignored unless Frame_Start_In=1.
  - RECEIVE: frame in progress.
- Transitions:
  - IDLE → RECEIVE on an edge with Shift_En_In=1 and Frame_Start_In=1. That bit is captured as the first bit and the count becomes 1.
  - RECEIVE with Shift_En_In=1 and Frame_Start_In=0: capture the bit and increment the count.
  - RECEIVE with Shift_En_In=1 and Frame_Start_In=1: abort the partial word with no flag; the bit becomes the first bit of the new frame and the count becomes 1.
  - Shift_En_In=0: no change to shift register, count or state.
- Bit placement:
  - MSB_FIRST=1: word = {word[WIDTH-2:0], bit}.
  - MSB_FIRST=0: word = {bit, word[WIDTH-1:1]}.
- Word completion (the edge that captures bit number WIDTH):
  - The assembled word, including that bit, is loaded into Parallel_Data_Out and Data_Valid_Out=1 immediately after that edge. Latency is 0 cycles after the last bit.
  - The count resets to 0.
  - Next state is RECEIVE if CONTINUOUS=1, otherwise IDLE.
  - In CONTINUOUS mode, Frame_Start_In on the bit that follows completion is accepted as a normal first bit.
- Handshake:
  - The word is consumed on an edge with Data_Valid_Out=1 and Data_Ready_In=1.
  - Data_Valid_Out deasserts after consumption unless a new word completes on the same edge. In that case the new word loads and Data_Valid_Out stays 1; this is not an overrun.
  - Parallel_Data_Out is unchanged while valid and not consumed.
- Overrun:
  - A word that completes while Data_Valid_Out=1 and Data_Ready_In=0 is dropped.
  - The held word is kept and Overrun_Out=1.
  - Overrun_Out is sticky until Overrun_Clear_In=1 or reset.
  - If Overrun_Clear_In and a new overrun occur on the same edge, the overrun wins and Overrun_Out stays 1.
- Bit_Count_Out ranges 0..WIDTH-1 between edges and never reads WIDTH.

Decomposition:
- Shared package shift_reg_pkg:
  - state enum (IDLE, RECEIVE).
  - count-width function clog2.
  - default WIDTH constant of 8, shared with the parallel register stage.
- One sub-module, sipo_output_holder: the one-word valid/ready holding register with overrun detection.
- The top level contains the FSM, the shift register and the counter.

Test Plan:
1. MSB_FIRST=1, WIDTH=8: Frame_Start_In on the first bit, serial bits 1,0,1,1,0,0,1,0 → after the 8th edge Parallel_Data_Out=8'hB2 and Data_Valid_Out=1; with Data_Ready_In=1 on the next edge, Data_Valid_Out=0.
2. MSB_FIRST=0, same bits → Parallel_Data_Out=8'h4D.
3. Restart mid-frame: send 5 bits, then Frame_Start_In with bits 8'hFF → Parallel_Data_Out=8'hFF, Overrun_Out=0, and Bit_Count_Out reads 1 after the restart edge.
4. Data_Ready_In held 0 for word 8'h11 then word 8'h22 (CONTINUOUS=1) → Parallel_Data_Out stays 8'h11 and Overrun_Out=1; Overrun_Clear_In=1 for one cycle → Overrun_Out=0.
5. Data_Ready_In=1 on the same edge that word 8'h22 completes while 8'h11 is valid → Parallel_Data_Out=8'h22, Data_Valid_Out stays 1, Overrun_Out=0.
6. Reset_In pulsed asynchronously between edges after 4 bits of a frame → all outputs are 0 immediately; the next 8 bits without Frame_Start_In are ignored and Data_Valid_Out stays 0.

Source files
------------

// File: rtl/serial_in_parallel_out_framed_pkg.sv
// Shared definitions for the framed deserializer and the parallel register stage.
//   state_t        : frame FSM states
//   clog2()        : width of a counter that must hold 0..value-1
//   DEFAULT_WIDTH  : word width shared with the downstream register stage
package shift_reg_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE    = 1'b0,
      RECEIVE = 1'b1
   } state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < value) r = i + 1;
      return r;
   endfunction

endpackage

// File: rtl/serial_in_parallel_out_framed_if.sv
// Bus bundle between the serial source / word consumer and the deserializer.
//   master : drives serial bit, strobe, frame start, ready and overrun clear
//   slave  : the deserializer; drives parallel word, valid, overrun, bit count
interface serial_in_parallel_out_framed_if
   import shift_reg_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) ();
   localparam int CW = clog2(WIDTH + 1);

   logic             Serial_Data_In;
   logic             Shift_En_In;
   logic             Frame_Start_In;
   logic             Data_Ready_In;
   logic             Overrun_Clear_In;
   logic [WIDTH-1:0] Parallel_Data_Out;
   logic             Data_Valid_Out;
   logic             Overrun_Out;
   logic [CW-1:0]    Bit_Count_Out;

   modport master (
      output Serial_Data_In, Shift_En_In, Frame_Start_In, Data_Ready_In, Overrun_Clear_In,
      input  Parallel_Data_Out, Data_Valid_Out, Overrun_Out, Bit_Count_Out
   );

   modport slave (
      input  Serial_Data_In, Shift_En_In, Frame_Start_In, Data_Ready_In, Overrun_Clear_In,
      output Parallel_Data_Out, Data_Valid_Out, Overrun_Out, Bit_Count_Out
   );
endinterface

// File: rtl/sipo_output_holder.sv
// One-word valid/ready holding register with sticky overrun detection.
//   Clk_In, Reset_In : falling-edge clock, async active-high reset
//   Load_In/Load_Data_In : a completed word is offered this edge
//   Ready_In         : consumer takes the held word when valid
//   Overrun_Clear_In : clears the sticky overrun flag
//   Data_Out/Valid_Out/Overrun_Out : held word, its valid, dropped-word flag
module sipo_output_holder #(
   parameter int WIDTH = 8
) (
   input  logic             Clk_In,
   input  logic             Reset_In,
   input  logic             Load_In,
   input  logic [WIDTH-1:0] Load_Data_In,
   input  logic             Ready_In,
   input  logic             Overrun_Clear_In,
   output logic [WIDTH-1:0] Data_Out,
   output logic             Valid_Out,
   output logic             Overrun_Out
);
   logic consume;
   logic drop;

   assign consume = Valid_Out & Ready_In;
   // A new word is lost only if the slot is still occupied after this edge.
   assign drop    = Load_In & Valid_Out & ~Ready_In;

   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         Data_Out  <= '0;
         Valid_Out <= 1'b0;
      end else if (Load_In && !drop) begin
         // Covers the empty slot and the consume-and-refill on the same edge.
         Data_Out  <= Load_Data_In;
         Valid_Out <= 1'b1;
      end else if (consume) begin
         Valid_Out <= 1'b0;
      end
   end

   // Set has priority so a clear cannot hide an overrun on the same edge.
   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In)              Overrun_Out <= 1'b0;
      else if (drop)             Overrun_Out <= 1'b1;
      else if (Overrun_Clear_In) Overrun_Out <= 1'b0;
   end
endmodule

// File: rtl/serial_in_parallel_out_framed.sv
// Framed serial-to-parallel deserializer.
//   Clk_In   : clock, all state changes on the falling edge
//   Reset_In : async active-high reset
//   bus      : serial input, frame start, strobe, parallel word handshake,
//              overrun flag and current bit count
// A frame begins on a strobed bit with Frame_Start_In; WIDTH strobed bits
// make a word, which is handed to the output holder on the completing edge.
module serial_in_parallel_out_framed
   import shift_reg_pkg::*;
#(
   parameter int WIDTH      = DEFAULT_WIDTH,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit CONTINUOUS = 1'b0
) (
   input  logic Clk_In,
   input  logic Reset_In,
   serial_in_parallel_out_framed_if.slave bus
);
   localparam int CW = clog2(WIDTH + 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d, shifted;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             word_done;

   // Register contents with the current serial bit already inserted.
   always_comb begin
      if (MSB_FIRST) shifted = {shift_q[WIDTH-2:0], bus.Serial_Data_In};
      else           shifted = {bus.Serial_Data_In, shift_q[WIDTH-1:1]};
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      cnt_d     = cnt_q;
      word_done = 1'b0;
      if (bus.Shift_En_In) begin
         unique case (state_q)
            IDLE: begin
               if (bus.Frame_Start_In) begin
                  shift_d = shifted;
                  cnt_d   = CW'(1);
                  state_d = RECEIVE;
               end
            end
            RECEIVE: begin
               shift_d = shifted;
               if (bus.Frame_Start_In) begin
                  // Restart: the partial word is silently abandoned.
                  cnt_d = CW'(1);
               end else if (cnt_q == CW'(WIDTH - 1)) begin
                  word_done = 1'b1;
                  cnt_d     = '0;
                  state_d   = CONTINUOUS ? RECEIVE : IDLE;
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(negedge Clk_In or posedge Reset_In) begin
      if (Reset_In) begin
         state_q <= IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.Bit_Count_Out = cnt_q;

   sipo_output_holder #(.WIDTH(WIDTH)) u_holder (
      .Clk_In           (Clk_In),
      .Reset_In         (Reset_In),
      .Load_In          (word_done),
      .Load_Data_In     (shifted),
      .Ready_In         (bus.Data_Ready_In),
      .Overrun_Clear_In (bus.Overrun_Clear_In),
      .Data_Out         (bus.Parallel_Data_Out),
      .Valid_Out        (bus.Data_Valid_Out),
      .Overrun_Out      (bus.Overrun_Out)
   );
endmodule
